// File: rtl/line_scanout_pkg.sv
// Shared constants and types for the line buffer scan-out path.
package line_scanout_pkg;

  // Each ping-pong bank holds 2**LB_BANK_BITS pixels; the top address bit picks the bank.
  localparam int unsigned LB_BANK_BITS = 9;
  localparam int unsigned LB_ADDR_W    = LB_BANK_BITS + 1;
  localparam int unsigned PIXEL_W      = 8;

  typedef logic [PIXEL_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StDrain
  } scan_state_e;

endpackage

// File: rtl/line_scanout_if.sv
// Signal bundle between the scan-out block and its surroundings: timing generator,
// renderer handshake, line buffer read port and the pixel stream to the colour stage.
interface line_scanout_if
  import line_scanout_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
);

  logic                  line_start;
  logic                  fill_done;
  logic [LB_ADDR_W-1:0]  rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] pixel;
  logic                  pixel_valid;
  logic                  line_done;
  logic                  underrun;
  logic                  write_bank;

  // Scan-out block side.
  modport master (
    input  line_start,
    input  fill_done,
    input  rd_data,
    output rd_addr,
    output pixel,
    output pixel_valid,
    output line_done,
    output underrun,
    output write_bank
  );

  // Environment side: timing generator, renderer and line buffer.
  modport slave (
    output line_start,
    output fill_done,
    output rd_data,
    input  rd_addr,
    input  pixel,
    input  pixel_valid,
    input  line_done,
    input  underrun,
    input  write_bank
  );

endinterface

// File: rtl/line_scanout.sv
// Read-side controller for the ping-pong line buffer: swaps banks at line start when
// the renderer has finished a bank, then scans the read bank out one pixel per clock
// with 2**SCALE_SHIFT horizontal pixel repeat.
module line_scanout
  import line_scanout_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned SCALE_SHIFT = 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  line_scanout_if.master bus
);

  localparam int unsigned CntW = (H_ACTIVE > 2) ? $clog2(H_ACTIVE) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(H_ACTIVE - 1);

  if ((H_ACTIVE >> SCALE_SHIFT) > (1 << LB_BANK_BITS)) begin : g_param_check
    $error("line_scanout: H_ACTIVE >> SCALE_SHIFT does not fit in one bank");
  end

  scan_state_e           state_q;
  // Clocks spent in the current state; the low SCALE_SHIFT bits act as the repeat count
  // and the remaining bits as the source pixel index.
  logic [CntW-1:0]       cnt_q;
  logic                  rd_bank_q;
  logic                  pending_q;
  logic                  act_d1_q;
  logic                  pixel_valid_q;
  logic                  line_done_q;
  logic                  underrun_q;
  logic                  write_bank_q;
  logic [DATA_WIDTH-1:0] pixel_q;
  logic                  swap;

  // A fill_done arriving in the same clock as line_start still counts as a fresh bank.
  assign swap = pending_q | bus.fill_done;

  // Scan FSM, bank ownership and the RAM/output-register pipeline.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      rd_bank_q     <= 1'b0;
      pending_q     <= 1'b0;
      act_d1_q      <= 1'b0;
      pixel_valid_q <= 1'b0;
      line_done_q   <= 1'b0;
      underrun_q    <= 1'b0;
      write_bank_q  <= 1'b1;
      pixel_q       <= '0;
    end else begin
      underrun_q    <= 1'b0;
      // act_d1_q marks the clock in which rd_data carries an active pixel.
      act_d1_q      <= (state_q == StActive);
      pixel_valid_q <= act_d1_q;
      pixel_q       <= act_d1_q ? bus.rd_data : '0;
      // Falling edge of the valid window.
      line_done_q   <= pixel_valid_q & ~act_d1_q;
      if (bus.fill_done) begin
        pending_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (bus.line_start) begin
            state_q <= StActive;
            if (swap) begin
              rd_bank_q    <= ~rd_bank_q;
              write_bank_q <= rd_bank_q;
              pending_q    <= 1'b0;
            end else begin
              underrun_q <= 1'b1;
            end
          end
        end
        StActive: begin
          if (cnt_q == CntLast) begin
            state_q <= StDrain;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDrain: begin
          if (cnt_q == CntW'(1)) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.rd_addr     = {rd_bank_q, LB_BANK_BITS'(cnt_q >> SCALE_SHIFT)};
  assign bus.pixel       = pixel_q;
  assign bus.pixel_valid = pixel_valid_q;
  assign bus.line_done   = line_done_q;
  assign bus.underrun    = underrun_q;
  assign bus.write_bank  = write_bank_q;

endmodule
